// File: rtl/wb_trace_buffer.sv
// Register write-back trace buffer: stamps every non-x0 register write with a
// cycle count and queues it in a FIFO drained through a valid/ready port.
module wb_trace_buffer #(
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned CYCLE_W = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     enable,
   input  logic                     ctrl_writeEnable,
   input  logic [4:0]               ctrl_writeReg,
   input  logic [31:0]              data_writeReg,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [CYCLE_W-1:0]       out_cycle,
   output logic [4:0]               out_reg,
   output logic [31:0]              out_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic [7:0]               drop_count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [CYCLE_W-1:0] cycle_ctr;
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;

   logic [CYCLE_W-1:0] mem_cycle [DEPTH];
   logic [4:0]         mem_reg   [DEPTH];
   logic [31:0]        mem_data  [DEPTH];

   logic capture;
   logic full;
   logic pop;
   logic push;
   logic drop;

   // A capture into a full FIFO still lands if the head leaves on the same edge.
   always_comb begin
      capture = enable & ctrl_writeEnable & (ctrl_writeReg != 5'd0);
      full    = (count == CNT_W'(DEPTH));
      pop     = out_valid & out_ready;
      push    = capture & (~full | pop);
      drop    = capture & full & ~pop;
   end

   // Control state: counter, pointers, occupancy and drop statistics.
   always_ff @(posedge clock) begin
      if (reset) begin
         cycle_ctr  <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         overflow   <= 1'b0;
         drop_count <= '0;
      end else begin
         if (enable) cycle_ctr <= cycle_ctr + CYCLE_W'(1);
         if (push)   wr_ptr    <= wr_ptr + PTR_W'(1);
         if (pop)    rd_ptr    <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
         end
      end
   end

   // Entry storage needs no reset; occupancy alone decides what is valid.
   always_ff @(posedge clock) begin
      if (!reset && push) begin
         mem_cycle[wr_ptr] <= cycle_ctr;
         mem_reg[wr_ptr]   <= ctrl_writeReg;
         mem_data[wr_ptr]  <= data_writeReg;
      end
   end

   // Head view is driven purely from state, zeroed while empty.
   always_comb begin
      out_valid = (count != '0);
      out_cycle = out_valid ? mem_cycle[rd_ptr] : '0;
      out_reg   = out_valid ? mem_reg[rd_ptr]   : '0;
      out_data  = out_valid ? mem_data[rd_ptr]  : '0;
   end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Self-checking bench for wb_trace_buffer: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_wb_trace_buffer;

   localparam int unsigned DEPTH = 16;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        ctrl_writeEnable = 1'b0;
   logic [4:0]  ctrl_writeReg = '0;
   logic [31:0] data_writeReg = '0;
   logic        out_ready = 1'b0;

   logic        out_valid;
   logic [15:0] out_cycle;
   logic [4:0]  out_reg;
   logic [31:0] out_data;
   logic [4:0]  count;
   logic        overflow;
   logic [7:0]  drop_count;

   logic        b_out_valid;
   logic [3:0]  b_out_cycle;
   logic [4:0]  b_out_reg;
   logic [31:0] b_out_data;
   logic [4:0]  b_count;
   logic        b_overflow;
   logic [7:0]  b_drop_count;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   wb_trace_buffer #(.DEPTH(DEPTH), .CYCLE_W(16)) dut (
      .clock(clock), .reset(reset), .enable(enable),
      .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
      .data_writeReg(data_writeReg), .out_valid(out_valid), .out_ready(out_ready),
      .out_cycle(out_cycle), .out_reg(out_reg), .out_data(out_data),
      .count(count), .overflow(overflow), .drop_count(drop_count)
   );

   // Narrow-stamp instance sharing the same stimulus, for counter wrap.
   wb_trace_buffer #(.DEPTH(DEPTH), .CYCLE_W(4)) dut_b (
      .clock(clock), .reset(reset), .enable(enable),
      .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
      .data_writeReg(data_writeReg), .out_valid(b_out_valid), .out_ready(out_ready),
      .out_cycle(b_out_cycle), .out_reg(b_out_reg), .out_data(b_out_data),
      .count(b_count), .overflow(b_overflow), .drop_count(b_drop_count)
   );

   // Reference model: an unbounded-cycle counter and a queue of events.
   typedef struct {
      int unsigned cyc;
      logic [4:0]  rd;
      logic [31:0] data;
   } ev_t;

   ev_t         q[$];
   int unsigned m_cyc   = 0;
   bit          m_ovf   = 0;
   int unsigned m_drops = 0;

   wire [67:0] dut_vec = {out_valid, count, out_cycle, out_reg, out_data, overflow, drop_count};
   wire [55:0] b_vec   = {b_out_valid, b_count, b_out_cycle, b_out_reg, b_out_data,
                          b_overflow, b_drop_count};

   function automatic logic [67:0] model_vec();
      logic [15:0] c = '0;
      logic [4:0]  r = '0;
      logic [31:0] d = '0;
      if (q.size() != 0) begin
         c = 16'(q[0].cyc % 65536);
         r = q[0].rd;
         d = q[0].data;
      end
      return {q.size() != 0, 5'(q.size()), c, r, d, m_ovf, 8'(m_drops)};
   endfunction

   function automatic logic [55:0] model_vec_b();
      logic [3:0]  c = '0;
      logic [4:0]  r = '0;
      logic [31:0] d = '0;
      if (q.size() != 0) begin
         c = 4'(q[0].cyc % 16);
         r = q[0].rd;
         d = q[0].data;
      end
      return {q.size() != 0, 5'(q.size()), c, r, d, m_ovf, 8'(m_drops)};
   endfunction

   // Apply the model for the coming edge, then advance past it.
   task automatic tick();
      ev_t e;
      if (reset) begin
         q.delete();
         m_cyc   = 0;
         m_ovf   = 0;
         m_drops = 0;
      end else begin
         if (q.size() != 0 && out_ready) void'(q.pop_front());
         if (enable && ctrl_writeEnable && ctrl_writeReg != 5'd0) begin
            if (q.size() < DEPTH) begin
               e.cyc = m_cyc; e.rd = ctrl_writeReg; e.data = data_writeReg;
               q.push_back(e);
            end else begin
               m_ovf = 1;
               if (m_drops < 255) m_drops++;
            end
         end
         if (enable) m_cyc++;
      end
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; ctrl_writeEnable = 1'b0; out_ready = 1'b0; enable = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if (dut_vec !== 68'd0) begin
         bad++; $display("FAIL reset_state got=%h exp=0", dut_vec);
      end
      total++;
      if (b_vec !== 56'd0) begin
         bad++; $display("FAIL reset_state_b got=%h exp=0", b_vec);
      end
   endtask

   task automatic test_basic_capture();
      do_reset();
      repeat (5) tick();
      ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd3; data_writeReg = 32'h0000002A;
      tick();
      ctrl_writeEnable = 1'b0;
      total++;
      if ({out_valid, out_cycle, out_reg, out_data, count} !== {1'b1, 16'd5, 5'd3, 32'd42, 5'd1}) begin
         bad++;
         $display("FAIL basic_capture got v=%0d c=%0d r=%0d d=%0d n=%0d exp v=1 c=5 r=3 d=42 n=1",
                  out_valid, out_cycle, out_reg, out_data, count);
      end
   endtask

   task automatic test_filter_gate();
      do_reset();
      repeat (2) tick();
      ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd0; data_writeReg = 32'hFFFFFFFF;
      tick();
      total++;
      if (count !== 5'd0 || out_valid !== 1'b0) begin
         bad++; $display("FAIL filter_x0 got n=%0d v=%0d exp n=0 v=0", count, out_valid);
      end
      enable = 1'b0; ctrl_writeReg = 5'd7; data_writeReg = 32'h77;
      repeat (3) tick();
      total++;
      if (count !== 5'd0 || out_valid !== 1'b0) begin
         bad++; $display("FAIL enable_gate got n=%0d v=%0d exp n=0 v=0", count, out_valid);
      end
      enable = 1'b1; ctrl_writeReg = 5'd5; data_writeReg = 32'h55;
      tick();
      ctrl_writeEnable = 1'b0;
      total++;
      if (out_cycle !== 16'd3 || out_reg !== 5'd5) begin
         bad++; $display("FAIL counter_hold got c=%0d r=%0d exp c=3 r=5", out_cycle, out_reg);
      end
   endtask

   task automatic test_drain_backpressure();
      logic [4:0]  order[$];
      logic [4:0]  hr;
      logic [31:0] hd;
      do_reset();
      ctrl_writeEnable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         ctrl_writeReg = 5'(i + 1); data_writeReg = 32'((i + 1) * 10);
         tick();
      end
      ctrl_writeEnable = 1'b0;
      for (int i = 0; i < 10; i++) begin
         out_ready = (i % 2 == 0);
         hr = out_reg; hd = out_data;
         if (out_ready && out_valid) order.push_back(out_reg);
         tick();
         if (!out_ready && out_valid) begin
            total++;
            if (out_reg !== hr || out_data !== hd) begin
               bad++; $display("FAIL head_stable got r=%0d d=%0d exp r=%0d d=%0d", out_reg, out_data, hr, hd);
            end
         end
         total++;
         if (dut_vec !== model_vec()) begin
            bad++; $display("FAIL drain_step%0d got=%h exp=%h", i, dut_vec, model_vec());
         end
      end
      out_ready = 1'b0;
      total++;
      if (order.size() != 4 || order[0] !== 5'd1 || order[1] !== 5'd2 || order[2] !== 5'd3 || order[3] !== 5'd4) begin
         bad++; $display("FAIL drain_order got n=%0d exp 1,2,3,4", order.size());
      end
   endtask

   task automatic fill(input int n);
      ctrl_writeEnable = 1'b1;
      for (int i = 0; i < n; i++) begin
         ctrl_writeReg = 5'(i % 31 + 1); data_writeReg = 32'(i * 3 + 1);
         tick();
      end
      ctrl_writeEnable = 1'b0;
   endtask

   task automatic test_overflow();
      do_reset();
      fill(18);
      total++;
      if (count !== 5'd16 || overflow !== 1'b1 || drop_count !== 8'd2) begin
         bad++; $display("FAIL overflow got n=%0d o=%0d dc=%0d exp n=16 o=1 dc=2", count, overflow, drop_count);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         total++;
         if (out_reg !== 5'(i + 1) || out_data !== 32'(i * 3 + 1)) begin
            bad++; $display("FAIL overflow_drain%0d got r=%0d d=%0d exp r=%0d d=%0d", i, out_reg, out_data, i + 1, i * 3 + 1);
         end
         tick();
      end
      out_ready = 1'b0;
      total++;
      if (dut_vec !== model_vec() || out_valid !== 1'b0) begin
         bad++; $display("FAIL overflow_empty got=%h exp=%h", dut_vec, model_vec());
      end
   endtask

   task automatic test_full_push_pop();
      do_reset();
      fill(16);
      out_ready = 1'b1; ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd9; data_writeReg = 32'd99;
      tick();
      ctrl_writeEnable = 1'b0;
      total++;
      if (count !== 5'd16 || drop_count !== 8'd0 || overflow !== 1'b0) begin
         bad++; $display("FAIL full_push_pop got n=%0d dc=%0d o=%0d exp n=16 dc=0 o=0", count, drop_count, overflow);
      end
      for (int i = 0; i < 15; i++) tick();
      total++;
      if (out_reg !== 5'd9 || out_data !== 32'd99 || count !== 5'd1) begin
         bad++; $display("FAIL full_last got r=%0d d=%0d n=%0d exp r=9 d=99 n=1", out_reg, out_data, count);
      end
      tick();
      out_ready = 1'b0;
      total++;
      if (dut_vec !== model_vec() || out_valid !== 1'b0) begin
         bad++; $display("FAIL full_empty got=%h exp=%h", dut_vec, model_vec());
      end
   endtask

   task automatic test_wrap();
      do_reset();
      repeat (15) tick();
      ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd2; data_writeReg = 32'd2;
      tick();
      ctrl_writeReg = 5'd3; data_writeReg = 32'd3;
      tick();
      ctrl_writeEnable = 1'b0;
      total++;
      if (b_out_cycle !== 4'd15 || out_cycle !== 16'd15) begin
         bad++; $display("FAIL wrap_first got b=%0d a=%0d exp 15", b_out_cycle, out_cycle);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      total++;
      if (b_out_cycle !== 4'd0 || b_out_reg !== 5'd3 || out_cycle !== 16'd16) begin
         bad++; $display("FAIL wrap_second got b=%0d r=%0d a=%0d exp b=0 r=3 a=16", b_out_cycle, b_out_reg, out_cycle);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      fill(18);
      out_ready = 1'b1;
      repeat (13) tick();
      total++;
      if (count !== 5'd3 || overflow !== 1'b1) begin
         bad++; $display("FAIL pre_reset got n=%0d o=%0d exp n=3 o=1", count, overflow);
      end
      reset = 1'b1; ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd4;
      tick();
      reset = 1'b0; ctrl_writeEnable = 1'b0; out_ready = 1'b0;
      total++;
      if ({count, out_valid, overflow, drop_count} !== 15'd0) begin
         bad++; $display("FAIL reset_mid got n=%0d v=%0d o=%0d dc=%0d exp all 0", count, out_valid, overflow, drop_count);
      end
   endtask

   task automatic test_saturate();
      do_reset();
      fill(16 + 260);
      total++;
      if (drop_count !== 8'd255 || overflow !== 1'b1 || count !== 5'd16) begin
         bad++; $display("FAIL saturate got dc=%0d o=%0d n=%0d exp dc=255 o=1 n=16", drop_count, overflow, count);
      end
   endtask

   task automatic test_random();
      int rate;
      do_reset();
      for (int i = 0; i < 800; i++) begin
         if (i % 100 == 0) rate = $urandom_range(10, 95);
         reset            = ($urandom_range(0, 299) == 0);
         enable           = ($urandom_range(0, 9) != 0);
         ctrl_writeEnable = ($urandom_range(0, 3) != 0);
         ctrl_writeReg    = 5'($urandom_range(0, 31));
         data_writeReg    = $urandom;
         out_ready        = ($urandom_range(0, 99) < rate);
         tick();
         total++;
         if (dut_vec !== model_vec()) begin
            bad++; $display("FAIL random%0d got=%h exp=%h", i, dut_vec, model_vec());
         end
         total++;
         if (b_vec !== model_vec_b()) begin
            bad++; $display("FAIL random_b%0d got=%h exp=%h", i, b_vec, model_vec_b());
         end
      end
      reset = 1'b0; ctrl_writeEnable = 1'b0; out_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic_capture();
      test_filter_gate();
      test_drain_backpressure();
      test_overflow();
      test_full_push_pop();
      test_wrap();
      test_reset_mid();
      test_saturate();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
